matmul_sequencer: RTL and testbench

- Top-level controller for one N x N systolic matrix multiply.
- Sequences weight preload into the array, then skewed activation feed, then the result-arranger accumulation window.
- Holds the arranged N*N result valid until the consumer accepts it.
- Sits between the host command interface and the systolic array plus result-arranger pair; drives only control, never data.

---
 rtl/matmul_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: control sequencer for one N x N systolic matrix multiply.
// It preloads the weights, feeds the skewed activations, opens the
// result-arranger accumulation window, and then holds the result until the
// consumer accepts it. It drives control signals only and never data.
// Optional feature: define MATMUL_PERF_CNT_EN to add the perf_ops and
// perf_stall saturating event counters.
module matmul_sequencer #(
  parameter int N             = 4,
  parameter int ARRAY_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  output logic                   start_ready,
  input  logic                   abort,
  output logic                   wt_load_en,
  output logic [$clog2(N)-1:0]   wt_row_sel,
  output logic                   act_feed_en,
  output logic [$clog2(2*N)-1:0] act_step,
  output logic                   start_arranging,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   busy
`ifdef MATMUL_PERF_CNT_EN
  ,
  output logic [31:0]            perf_ops,
  output logic [31:0]            perf_stall
`endif
);

  localparam int WW = $clog2(N);
  localparam int SW = $clog2(2*N);
  localparam int TW = $clog2(ARRAY_LATENCY + 2*N + 1);

  localparam logic [WW-1:0] W_LAST      = WW'(N - 1);
  localparam logic [TW-1:0] T_FEED_LAST = TW'(2*N - 2);
  localparam logic [TW-1:0] T_END       = TW'(ARRAY_LATENCY + 2*N - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [TW-1:0] t_q, t_d;

  logic          start_ready_q, start_ready_d;
  logic          busy_q, busy_d;
  logic          wt_load_en_q, wt_load_en_d;
  logic [WW-1:0] wt_row_sel_q, wt_row_sel_d;
  logic          act_feed_en_q, act_feed_en_d;
  logic [SW-1:0] act_step_q, act_step_d;
  logic          start_arranging_q, start_arranging_d;
  logic          result_valid_q, result_valid_d;

  // Next state and counters; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    t_d     = t_q;
    if (abort) begin
      state_d = S_IDLE;
      wcnt_d  = '0;
      t_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD;
            wcnt_d  = '0;
          end
        end
        S_LOAD: begin
          if (wcnt_q == W_LAST) begin
            state_d = S_FEED;
            wcnt_d  = '0;
            t_d     = '0;
          end else begin
            wcnt_d = wcnt_q + WW'(1);
          end
        end
        S_FEED: begin
          t_d = t_q + TW'(1);
          if (t_q == T_END) begin
            state_d = S_DONE;
          end else if (t_q == T_FEED_LAST) begin
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          t_d = t_q + TW'(1);
          if (t_q == T_END) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          // t stays at its ceiling (ARRAY_LATENCY+2N) while the result is held.
          if (result_ready) begin
            state_d = S_IDLE;
            t_d     = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          wcnt_d  = '0;
          t_d     = '0;
        end
      endcase
    end
  end

  // Decode the registered outputs from the upcoming state and counters.
  always_comb begin
    start_ready_d     = (state_d == S_IDLE);
    busy_d            = (state_d != S_IDLE);
    wt_load_en_d      = (state_d == S_LOAD);
    wt_row_sel_d      = (state_d == S_LOAD) ? wcnt_d : '0;
    act_feed_en_d     = 1'b0;
    act_step_d        = '0;
    start_arranging_d = 1'b0;
    result_valid_d    = 1'b0;
    if (state_d == S_FEED || state_d == S_DRAIN) begin
      if (t_d <= T_FEED_LAST) begin
        act_feed_en_d = 1'b1;
        act_step_d    = t_d[SW-1:0];
      end
      start_arranging_d = (int'({1'b0, t_d}) >= ARRAY_LATENCY);
    end
    if (state_d == S_DONE) begin
      // The arranger saturates at 2N accumulates, so holding enable keeps the result.
      start_arranging_d = 1'b1;
      result_valid_d    = 1'b1;
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= S_IDLE;
      wcnt_q            <= '0;
      t_q               <= '0;
      start_ready_q     <= 1'b1;
      busy_q            <= 1'b0;
      wt_load_en_q      <= 1'b0;
      wt_row_sel_q      <= '0;
      act_feed_en_q     <= 1'b0;
      act_step_q        <= '0;
      start_arranging_q <= 1'b0;
      result_valid_q    <= 1'b0;
    end else begin
      state_q           <= state_d;
      wcnt_q            <= wcnt_d;
      t_q               <= t_d;
      start_ready_q     <= start_ready_d;
      busy_q            <= busy_d;
      wt_load_en_q      <= wt_load_en_d;
      wt_row_sel_q      <= wt_row_sel_d;
      act_feed_en_q     <= act_feed_en_d;
      act_step_q        <= act_step_d;
      start_arranging_q <= start_arranging_d;
      result_valid_q    <= result_valid_d;
    end
  end

  assign start_ready     = start_ready_q;
  assign busy            = busy_q;
  assign wt_load_en      = wt_load_en_q;
  assign wt_row_sel      = wt_row_sel_q;
  assign act_feed_en     = act_feed_en_q;
  assign act_step        = act_step_q;
  assign start_arranging = start_arranging_q;
  assign result_valid    = result_valid_q;

`ifdef MATMUL_PERF_CNT_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Saturating event counts; abort does not clear them.
  always_comb begin
    perf_ops_d   = perf_ops_q;
    perf_stall_d = perf_stall_q;
    if (state_q == S_DONE && result_ready && !abort && perf_ops_q != '1) begin
      perf_ops_d = perf_ops_q + 32'd1;
    end
    if (state_q == S_DONE && !result_ready && perf_stall_q != '1) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ops_q   <= perf_ops_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: runs two sequencers (ARRAY_LATENCY 2 and 0) from one
// shared stimulus. Both are checked every cycle against a model that tracks
// how many cycles have passed since a start was accepted.
module tb_matmul_sequencer;
  localparam int N  = 4;
  localparam int L0 = 2;
  localparam int L1 = 0;
  localparam int WW = $clog2(N);
  localparam int SW = $clog2(2*N);
  localparam int VW = 6 + WW + SW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic result_ready = 1'b1;

  logic          sr0, bz0, wl0, fe0, ar0, rv0;
  logic [WW-1:0] row0;
  logic [SW-1:0] st0;
  logic          sr1, bz1, wl1, fe1, ar1, rv1;
  logic [WW-1:0] row1;
  logic [SW-1:0] st1;
`ifdef MATMUL_PERF_CNT_EN
  logic [31:0] po0, ps0, po1, ps1;
  longint m_ops0 = 0, m_stall0 = 0, m_ops1 = 0, m_stall1 = 0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int k0 = 0;
  int k1 = 0;

  always #5 clk = ~clk;

  matmul_sequencer #(.N(N), .ARRAY_LATENCY(L0)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start), .start_ready(sr0), .abort(abort),
    .wt_load_en(wl0), .wt_row_sel(row0), .act_feed_en(fe0), .act_step(st0),
    .start_arranging(ar0), .result_valid(rv0), .result_ready(result_ready), .busy(bz0)
`ifdef MATMUL_PERF_CNT_EN
    , .perf_ops(po0), .perf_stall(ps0)
`endif
  );

  matmul_sequencer #(.N(N), .ARRAY_LATENCY(L1)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start), .start_ready(sr1), .abort(abort),
    .wt_load_en(wl1), .wt_row_sel(row1), .act_feed_en(fe1), .act_step(st1),
    .start_arranging(ar1), .result_valid(rv1), .result_ready(result_ready), .busy(bz1)
`ifdef MATMUL_PERF_CNT_EN
    , .perf_ops(po1), .perf_stall(ps1)
`endif
  );

  // Cycle in which result_valid first appears, counting the start cycle as 0.
  function automatic int total(int lat);
    return N + lat + 2*N + 1;
  endfunction

  // Run position after one clock edge: 0 = idle, k>=1 = k cycles after start.
  function automatic int next_k(int k, int lat, logic s, logic a, logic r);
    if (a) return 0;
    if (k == 0) return s ? 1 : 0;
    if (k == total(lat)) return r ? 0 : k;
    return k + 1;
  endfunction

  // Expected outputs for run position k:
  // {start_ready, busy, wt_load_en, wt_row_sel, act_feed_en, act_step, start_arranging, result_valid}
  function automatic logic [VW-1:0] exp_vec(int k, int lat);
    int t;
    logic wl, inft, feed, val, arr;
    logic [WW-1:0] row;
    logic [SW-1:0] st;
    t    = k - 1 - N;
    wl   = (k >= 1 && k <= N);
    inft = (k > N && k < total(lat));
    feed = inft && (t <= 2*N - 2);
    val  = (k == total(lat));
    arr  = (inft && t >= lat) || val;
    row  = wl ? WW'(k - 1) : '0;
    st   = feed ? SW'(t) : '0;
    return {(k == 0), (k != 0), wl, row, feed, st, arr, val};
  endfunction

  // Reference model: advances on each clock edge, cleared by the async reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k0 = 0;
      k1 = 0;
    end else begin
`ifdef MATMUL_PERF_CNT_EN
      if (k0 == total(L0) && result_ready && !abort) m_ops0++;
      if (k0 == total(L0) && !result_ready) m_stall0++;
      if (k1 == total(L1) && result_ready && !abort) m_ops1++;
      if (k1 == total(L1) && !result_ready) m_stall1++;
`endif
      k0 = next_k(k0, L0, start, abort, result_ready);
      k1 = next_k(k1, L1, start, abort, result_ready);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("lat2_outputs", 64'({sr0, bz0, wl0, row0, fe0, st0, ar0, rv0}), 64'(exp_vec(k0, L0)));
    chk("lat0_outputs", 64'({sr1, bz1, wl1, row1, fe1, st1, ar1, rv1}), 64'(exp_vec(k1, L1)));
`ifdef MATMUL_PERF_CNT_EN
    chk("lat2_perf_ops", 64'(po0), 64'(m_ops0));
    chk("lat2_perf_stall", 64'(ps0), 64'(m_stall0));
    chk("lat0_perf_ops", 64'(po1), 64'(m_ops1));
    chk("lat0_perf_stall", 64'(ps1), 64'(m_stall1));
`endif
  endtask

  // One cycle: inputs change 2 time units after the rising edge; outputs are compared at the falling edge.
  task automatic tick(input logic s, input logic a, input logic r);
    @(posedge clk);
    #2;
    start = s;
    abort = a;
    result_ready = r;
    #3;
    compare_all();
  endtask

  int f_feed0, f_arr0, f_val0, f_idle0, f_arr1, f_val1, arr_cnt1;

  initial begin
    // Reset held for a few cycles, then released between edges.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
    reset_n = 1'b1;
    tick(1'b0, 1'b0, 1'b1);
    chk("reset_start_ready", 64'(sr0), 64'd1);

    // Nominal run: start accepted in cycle 0.
    f_feed0 = -1; f_arr0 = -1; f_val0 = -1; f_idle0 = -1; f_arr1 = -1; f_val1 = -1; arr_cnt1 = 0;
    for (int c = 0; c < 20; c++) begin
      tick(c == 0, 1'b0, 1'b1);
      if (c == 1) chk("nom_first_wt_load", 64'({wl0, row0}), 64'({1'b1, WW'(0)}));
      if (c == 4) chk("nom_last_wt_row", 64'(row0), 64'd3);
      if (c == 11) chk("nom_last_act_step", 64'({fe0, st0}), 64'({1'b1, SW'(6)}));
      if (fe0 && f_feed0 < 0) f_feed0 = c;
      if (ar0 && f_arr0 < 0) f_arr0 = c;
      if (rv0 && f_val0 < 0) f_val0 = c;
      if (c > 0 && sr0 && f_val0 >= 0 && f_idle0 < 0) f_idle0 = c;
      if (ar1 && f_arr1 < 0) f_arr1 = c;
      if (rv1 && f_val1 < 0) f_val1 = c;
      if (ar1 && !rv1) arr_cnt1++;
    end
    chk("nom_first_feed", 64'(f_feed0), 64'd5);
    chk("nom_first_arrange", 64'(f_arr0), 64'd7);
    chk("nom_result_valid", 64'(f_val0), 64'd15);
    chk("nom_back_to_idle", 64'(f_idle0), 64'd16);
    chk("lat0_first_arrange", 64'(f_arr1), 64'd5);
    chk("lat0_result_valid", 64'(f_val1), 64'd13);
    chk("lat0_arrange_cycles", 64'(arr_cnt1), 64'd8);

    // Back-pressure: result_ready low through cycle 19 while start pulses are ignored.
    for (int c = 0; c < 24; c++) begin
      tick(c == 0 || c == 16 || c == 18, 1'b0, c >= 20);
      if (c == 19) chk("bp_held", 64'({rv0, ar0, bz0}), 64'b111);
      if (c == 21) chk("bp_released", 64'({sr0, bz0, rv0}), 64'b100);
    end

    // Abort in cycle 8, then a fresh nominal run.
    for (int c = 0; c < 12; c++) begin
      tick(c == 0, c == 8, 1'b1);
      if (c == 9) chk("abort_idle", 64'({sr0, bz0, wl0, fe0, ar0, rv0}), 64'b100000);
    end
    f_val0 = -1;
    for (int c = 0; c < 18; c++) begin
      tick(c == 0, 1'b0, 1'b1);
      if (rv0 && f_val0 < 0) f_val0 = c;
    end
    chk("post_abort_valid", 64'(f_val0), 64'd15);

    // Start and result_ready together while in DONE.
    for (int c = 0; c < 20; c++) begin
      tick(c == 0 || c == 16, 1'b0, c >= 16);
      if (c == 15) chk("both_done", 64'(rv0), 64'd1);
      if (c == 17 || c == 18) chk("both_no_reload", 64'({sr0, wl0, bz0}), 64'b100);
    end

    // Asynchronous reset in the middle of DRAIN (cycle 13).
    for (int c = 0; c < 14; c++) tick(c == 0, 1'b0, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    compare_all();
    chk("async_reset_now", 64'({sr0, bz0, ar0, rv0}), 64'b1000);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(1'b0, 1'b0, 1'b1);
      chk("after_reset_no_valid", 64'({sr0, rv0}), 64'b10);
    end

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      tick(($urandom % 4) == 0, ($urandom % 40) == 0, ($urandom % 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
